// File: rtl/mac_accumulator.sv
// Handshaked dot-product accumulator behind the 16x16 multiplier.
// Sums runs of unsigned products, with saturation or wrap, a term count and forced end-of-run.
module mac_accumulator #(
   parameter int unsigned PROD_W    = 32,
   parameter int unsigned ACC_W     = 40,
   parameter int unsigned CNT_W     = 11,
   parameter int unsigned MAX_TERMS = 1024,
   parameter bit          SATURATE  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod_data,
   input  logic              prod_last,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_ovf
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

   localparam logic [CNT_W:0] MaxCnt = (CNT_W+1)'(MAX_TERMS);

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   res_data_q, res_data_d;
   logic [CNT_W-1:0]   res_count_q, res_count_d;
   logic               res_ovf_q, res_ovf_d;

   logic               p_xfer, first, end_run, ovf_inc;
   logic [ACC_W:0]     ext, sum;
   logic [CNT_W:0]     cnt_inc;
   logic [ACC_W-1:0]   acc_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else if (p_xfer) begin
         state_d = end_run ? HOLD : ACCUM;
      end else if (state_q == HOLD && res_ready) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      prod_ready = (state_q != HOLD) || res_ready;
      res_valid  = (state_q == HOLD);
      res_data   = res_data_q;
      res_count  = res_count_q;
      res_ovf    = res_ovf_q;
   end

   // A beat taken in IDLE or passed through HOLD starts a fresh run.
   always_comb begin
      p_xfer  = prod_valid && prod_ready;
      first   = (state_q != ACCUM);
      ext     = {{(ACC_W+1-PROD_W){1'b0}}, prod_data};
      sum     = first ? ext : ({1'b0, acc_q} + ext);
      cnt_inc = first ? {{CNT_W{1'b0}}, 1'b1} : ({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1});
      ovf_inc = sum[ACC_W] | (~first & ovf_q);
      acc_inc = (SATURATE && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
      end_run = p_xfer && (prod_last || (cnt_inc == MaxCnt));

      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      res_data_d  = res_data_q;
      res_count_d = res_count_q;
      res_ovf_d   = res_ovf_q;

      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (end_run) begin
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         res_data_d  = acc_inc;
         res_count_d = cnt_inc[CNT_W-1:0];
         res_ovf_d   = ovf_inc;
      end else if (p_xfer) begin
         acc_d = acc_inc;
         cnt_d = cnt_inc[CNT_W-1:0];
         ovf_d = ovf_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         res_data_q  <= '0;
         res_count_q <= '0;
         res_ovf_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         res_data_q  <= res_data_d;
         res_count_q <= res_count_d;
         res_ovf_q   <= res_ovf_d;
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: three instances (saturating, wrapping, MAX_TERMS=4)
// share clock, reset, clr, data and res_ready; each has its own prod_valid and result queue.
module tb_mac_accumulator;

   typedef struct packed {
      logic [39:0] d;
      logic [10:0] c;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [2:0]  pv = '0;
   logic [31:0] pd = '0;
   logic        pl = 1'b0;
   logic        rr = 1'b1;
   logic [2:0]  pr;
   logic [2:0]  rv;
   logic [2:0]  ro;
   logic [39:0] rd [3];
   logic [10:0] rc [3];

   int errors = 0;
   int checks = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   always #5 clk = ~clk;

   mac_accumulator #(.SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .prod_valid(pv[0]), .prod_ready(pr[0]), .prod_data(pd), .prod_last(pl),
      .res_valid(rv[0]), .res_ready(rr), .res_data(rd[0]), .res_count(rc[0]), .res_ovf(ro[0]));

   mac_accumulator #(.SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .prod_valid(pv[1]), .prod_ready(pr[1]), .prod_data(pd), .prod_last(pl),
      .res_valid(rv[1]), .res_ready(rr), .res_data(rd[1]), .res_count(rc[1]), .res_ovf(ro[1]));

   mac_accumulator #(.MAX_TERMS(4)) u_max4 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .prod_valid(pv[2]), .prod_ready(pr[2]), .prod_data(pd), .prod_last(pl),
      .res_valid(rv[2]), .res_ready(rr), .res_data(rd[2]), .res_count(rc[2]), .res_ovf(ro[2]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int sel, input logic [39:0] d, input logic [10:0] c, input logic o);
      exp_t e;
      e = '{d: d, c: c, o: o};
      case (sel)
         0: qa.push_back(e);
         1: qb.push_back(e);
         default: qc.push_back(e);
      endcase
   endtask

   // Holds a beat on the selected instance until it is accepted at a rising edge.
   task automatic send(input int sel, input logic [31:0] d, input logic l);
      logic r;
      int   n;
      pv = '0;
      pv[sel] = 1'b1;
      pd = d;
      pl = l;
      n = 0;
      r = 1'b0;
      while (!r) begin
         @(negedge clk);
         r = pr[sel];
         @(posedge clk);
         #1;
         n++;
         if (!r && n > 100) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: inst %0d got no ready, expected ready within 100 cycles", sel);
            r = 1'b1;
         end
      end
   endtask

   task automatic mon(input int sel);
      exp_t e;
      exp_t a;
      bit   have;
      have = 1'b0;
      case (sel)
         0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
         1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
         default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
      endcase
      a = '{d: rd[sel], c: rc[sel], o: ro[sel]};
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL unexpected_result: inst %0d got data=%0h count=%0d ovf=%0b, expected none",
                  sel, a.d, a.c, a.o);
      end else if (a !== e) begin
         errors++;
         $display("FAIL result: inst %0d got data=%0h count=%0d ovf=%0b, expected data=%0h count=%0d ovf=%0b",
                  sel, a.d, a.c, a.o, e.d, e.c, e.o);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst_n && rv[i] && rr) mon(i);
      end
   end

   initial begin
      int n;

      #3;
      chk("reset_res_valid", 64'(rv), 64'h0);
      chk("reset_res_data", 64'(rd[0]), 64'h0);
      chk("reset_res_count", 64'(rc[0]), 64'h0);
      chk("reset_res_ovf", 64'(ro), 64'h0);
      #9 rst_n = 1'b1;
      #1;
      chk("reset_prod_ready", 64'(pr), 64'h7);
      @(posedge clk);
      #1;

      // Three-term run, result one cycle after the last beat.
      rr = 1'b1;
      push(0, 40'h2_FFFA_0003, 11'd3, 1'b0);
      send(0, 32'hFFFE_0001, 1'b0);
      send(0, 32'hFFFE_0001, 1'b0);
      send(0, 32'hFFFE_0001, 1'b1);
      pv = '0;
      chk("latency_res_valid", 64'(rv[0]), 64'h1);
      chk("latency_res_data", 64'(rd[0]), 64'h2_FFFA_0003);
      @(posedge clk);
      #1;

      // 257-term overflow: saturate vs wrap.
      push(0, 40'hFF_FFFF_FFFF, 11'd257, 1'b1);
      for (int i = 1; i <= 257; i++) send(0, 32'hFFFE_0001, i == 257);
      pv = '0;
      push(1, 40'h00_FDFE_0101, 11'd257, 1'b1);
      for (int i = 1; i <= 257; i++) send(1, 32'hFFFE_0001, i == 257);
      pv = '0;
      @(posedge clk);
      #1;

      // Forced end after four terms; the remainder starts a new run.
      push(2, 40'd20, 11'd4, 1'b0);
      push(2, 40'd10, 11'd2, 1'b0);
      for (int i = 1; i <= 6; i++) send(2, 32'd5, i == 6);
      pv = '0;
      @(posedge clk);
      #1;

      // Back-pressure in HOLD, then a pass-through single-beat run.
      rr = 1'b0;
      push(0, 40'h11, 11'd1, 1'b0);
      send(0, 32'h11, 1'b1);
      pd = 32'd7;
      pl = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_prod_ready", 64'(pr[0]), 64'h0);
         chk("hold_res_stable", {23'h0, rv[0], rd[0]}, {23'h0, 1'b1, 40'h11});
         @(posedge clk);
         #1;
      end
      push(0, 40'd7, 11'd1, 1'b0);
      rr = 1'b1;
      @(negedge clk);
      chk("hold_release_ready", 64'(pr[0]), 64'h1);
      @(posedge clk);
      #1;
      pv = '0;
      chk("passthru_res_valid", 64'(rv[0]), 64'h1);
      chk("passthru_res_data", 64'(rd[0]), 64'd7);
      @(posedge clk);
      #1;

      // clr discards a pending result.
      rr = 1'b0;
      send(0, 32'd55, 1'b1);
      pv = '0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("clr_drops_result", 64'(rv[0]), 64'h0);
      rr = 1'b1;

      // clr mid-run, with a beat presented alongside it.
      send(0, 32'd100, 1'b0);
      send(0, 32'd200, 1'b0);
      pd = 32'd300;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      pv = '0;
      chk("clr_mid_run_valid", 64'(rv[0]), 64'h0);
      push(0, 40'd3, 11'd2, 1'b0);
      send(0, 32'd1, 1'b0);
      send(0, 32'd2, 1'b1);
      pv = '0;
      @(posedge clk);
      #1;

      // Asynchronous reset mid-run.
      send(0, 32'd50, 1'b0);
      send(0, 32'd50, 1'b0);
      pv = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_res_valid", 64'(rv), 64'h0);
      chk("async_res_data", 64'(rd[0]), 64'h0);
      chk("async_res_count", 64'(rc[0]), 64'h0);
      chk("async_res_ovf", 64'(ro), 64'h0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(0, 40'd9, 11'd1, 1'b0);
      send(0, 32'd9, 1'b1);
      pv = '0;

      n = 0;
      while ((qa.size() + qb.size() + qc.size()) != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("queues_drained", 64'(qa.size() + qb.size() + qc.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Sequential accumulate stage directly downstream of the 16x16 Dadda multiplier. It consumes the 32-bit unsigned product stream and sums a variable-length run of products (a dot product) into a wide accumulator. It presents each finished sum on a valid/ready result port. It converts the purely combinational multiplier datapath into a handshaked pipeline element with saturation, term counting and forced termination.

Parameters:
PROD_W, 32, product width; must equal the multiplier output width.
ACC_W, 40, accumulator and result width; must be >= PROD_W+1.
CNT_W, 11, term-counter width.
MAX_TERMS, 1024, maximum terms per run; must be <= 2^CNT_W. Reaching this count forces end-of-run.
SATURATE, 1, 1 = clamp on overflow to all-ones; 0 = wrap modulo 2^ACC_W.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort of the current run and of any pending result
prod_valid  input  1  product beat valid
prod_ready  output  1  stage can accept a product beat
prod_data  input  PROD_W  unsigned product (multiplier output)
prod_last  input  1  marks the final term of a run
res_valid  output  1  result held and valid
res_ready  input  1  consumer accepts the result
res_data  output  ACC_W  accumulated sum
res_count  output  CNT_W  number of terms in the run; value MAX_TERMS is encoded as 0 when MAX_TERMS = 2^CNT_W
res_ovf  output  1  sticky: an overflow occurred during the run

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, cnt=0, ovf=0, res_valid=0, res_data=0, res_count=0, res_ovf=0. prod_ready evaluates to 1 once rst_n is high.
- States:
  - IDLE: no run in progress.
  - ACCUM: run in progress, at least 1 term taken.
  - HOLD: result pending.
- Handshakes:
  - prod_ready = (state != HOLD) || res_ready.
  - Product transfer = prod_valid && prod_ready.
  - Result transfer = res_valid && res_ready.
- Term transfer:
  - First term: in IDLE, or in HOLD via pass-through. The next sum is computed as sum = {0, prod_data} with cnt=1 and ovf=0.
  - Later terms: in ACCUM. The next sum is computed as sum = acc + zero-extended prod_data, done at ACC_W+1 bits. cnt increments.
  - Overflow is bit ACC_W of that sum. On overflow, ovf is set (sticky).
  - Stored value on overflow: with SATURATE=1, acc <= all-ones and stays there for the rest of the run. With SATURATE=0, acc <= low ACC_W bits.
- End of run: a term transfer with prod_last=1, or with new cnt == MAX_TERMS.
  - Next cycle: res_data = final acc, res_count = cnt, res_ovf = ovf, res_valid=1, state=HOLD.
  - Latency from the last accepted beat to res_valid is 1 cycle.
  - acc and cnt return to 0.
- Non-last transfer: state=ACCUM.
- HOLD:
  - res_* stay stable until the result transfer completes.
  - Result transfer with no product transfer: res_valid<=0, state=IDLE.
  - Result transfer and product transfer in the same cycle: that beat starts a new run. If the beat is also last, res_valid stays 1 with new contents (back-to-back single-term runs, full throughput). Otherwise state=ACCUM and res_valid<=0.
- Forced end: on forced termination, later beats begin a new run; no beat is dropped.
- clr (highest priority, synchronous):
  - Next cycle: state=IDLE, acc=0, cnt=0, ovf=0, res_valid=0.
  - A result already presented and not yet accepted is discarded.
  - A beat presented in the same cycle as clr is consumed and discarded.
- prod_valid=0 during ACCUM: acc is held; gaps between beats are unlimited.
- Async reset mid-run or mid-HOLD: all state returns immediately to the reset values; the partial sum is lost.

Test Plan:
- 3 beats of 0xFFFE0001, last on the 3rd, res_ready=1 -> 1 cycle later: res_valid=1, res_data=0x2_FFFA_0003, res_count=3, res_ovf=0.
- 257 beats of 0xFFFE0001, SATURATE=1 -> res_data=0xFF_FFFF_FFFF, res_ovf=1. Repeat with SATURATE=0 -> res_data=0x00_FDFE_0101, res_ovf=1.
- MAX_TERMS=4, 6 beats of value 5, prod_last only on the 6th:
  - First result: res_data=20, res_count=4.
  - Second result: res_data=10, res_count=2.
- HOLD with res_ready=0 for 5 cycles while prod_valid=1 -> prod_ready=0 and res_* stable. Then res_ready=1 with a single-beat last of 7 -> the next result appears the following cycle with res_data=7 and res_valid high continuously.
- clr asserted after 2 of 4 beats, then a new run of 1,2 with last -> res_data=3, res_count=2 (no residue from the aborted run).
- rst_n pulled low asynchronously mid-run -> all outputs return to reset values without a clock edge. After release, a single last beat of 9 -> res_data=9.
